// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Brief    : PRBS-14 receive checker (x^14+x^5+x^3+x+1 taps) with hunt/lock
//            FSM, windowed loss-of-lock detection and saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_checker #(
    parameter int LOCK_CNT   = 32,
    parameter int WINDOW     = 256,
    parameter int UNLOCK_ERR = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clr_counts,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] err_count,
    output logic [31:0] bit_count
);

    localparam int c_MW = $clog2(LOCK_CNT + 1);
    localparam int c_WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_EW = $clog2(UNLOCK_ERR + 1);
    localparam logic [c_MW-1:0] c_LOCK     = c_MW'(LOCK_CNT);
    localparam logic [c_WW-1:0] c_WIN_LAST = c_WW'(WINDOW - 1);
    localparam logic [c_EW-1:0] c_UNLOCK   = c_EW'(UNLOCK_ERR);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          r_state;
    logic [13:0]     r_hist;
    logic [13:0]     r_gen;
    logic [3:0]      r_fill;
    logic [c_MW-1:0] r_match;
    logic [c_WW-1:0] r_win;
    logic [c_EW-1:0] r_werr;
    logic            r_locked;
    logic            r_err_pulse;
    logic [31:0]     r_err_cnt;
    logic [31:0]     r_bit_cnt;

    logic            w_hunt_pred;
    logic            w_hunt_ok;
    logic            w_gen_pred;
    logic            w_lock_err;
    logic [c_MW-1:0] w_match_next;
    logic [c_EW-1:0] w_werr_next;
    logic [31:0]     w_err_inc;
    logic [31:0]     w_bit_inc;

    // An all-zero history predicts zero forever, so it must never count as a match.
    assign w_hunt_pred  = r_hist[13] ^ r_hist[4] ^ r_hist[2] ^ r_hist[0];
    assign w_hunt_ok    = (din == w_hunt_pred) && (r_hist != 14'd0);
    assign w_gen_pred   = r_gen[13] ^ r_gen[4] ^ r_gen[2] ^ r_gen[0];
    assign w_lock_err   = (din != w_gen_pred);
    assign w_match_next = r_match + 1'b1;
    assign w_werr_next  = r_werr + c_EW'(w_lock_err);
    assign w_err_inc    = (r_err_cnt == 32'hFFFF_FFFF) ? r_err_cnt : r_err_cnt + 32'd1;
    assign w_bit_inc    = (r_bit_cnt == 32'hFFFF_FFFF) ? r_bit_cnt : r_bit_cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_hist      <= '0;
            r_gen       <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_werr      <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_bit_cnt   <= '0;
        end else begin
            if (din_valid) begin
                r_err_pulse <= 1'b0;
                case (r_state)
                    ST_FILL: begin
                        r_hist <= {r_hist[12:0], din};
                        if (r_fill == 4'd13) begin
                            r_fill  <= '0;
                            r_match <= '0;
                            r_state <= ST_HUNT;
                        end else begin
                            r_fill <= r_fill + 4'd1;
                        end
                    end
                    ST_HUNT: begin
                        r_hist <= {r_hist[12:0], din};
                        if (w_hunt_ok) begin
                            if (w_match_next == c_LOCK) begin
                                r_state  <= ST_LOCKED;
                                r_gen    <= {r_hist[12:0], din};
                                r_locked <= 1'b1;
                                r_match  <= '0;
                                r_win    <= '0;
                                r_werr   <= '0;
                            end else begin
                                r_match <= w_match_next;
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-running: a line error must not corrupt later predictions.
                        r_gen       <= {r_gen[12:0], w_gen_pred};
                        r_bit_cnt   <= w_bit_inc;
                        r_err_pulse <= w_lock_err;
                        if (w_lock_err) begin
                            r_err_cnt <= w_err_inc;
                        end
                        if (w_werr_next == c_UNLOCK) begin
                            r_state  <= ST_FILL;
                            r_locked <= 1'b0;
                            r_hist   <= '0;
                            r_fill   <= '0;
                            r_win    <= '0;
                            r_werr   <= '0;
                        end else if (r_win == c_WIN_LAST) begin
                            r_win  <= '0;
                            r_werr <= '0;
                        end else begin
                            r_win  <= r_win + 1'b1;
                            r_werr <= w_werr_next;
                        end
                    end
                    default: r_state <= ST_FILL;
                endcase
            end else begin
                r_err_pulse <= 1'b0;
            end
            // Placed last so a clear wins over a same-cycle increment.
            if (clr_counts) begin
                r_err_cnt <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_cnt;
    assign bit_count = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_checker
// Brief    : Self-checking bench for prbs_checker against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

    localparam int LOCK_CNT   = 32;
    localparam int WINDOW     = 256;
    localparam int UNLOCK_ERR = 8;
    localparam longint SAT    = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_counts = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] bit_count;

    always #5 clk = ~clk;

    prbs_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .WINDOW    (WINDOW),
        .UNLOCK_ERR(UNLOCK_ERR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr_counts(clr_counts),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [65:0] got;
    logic [65:0] want;

    // Reference PRBS-14 source
    logic [13:0] src;

    task automatic src_step(output bit b);
        b   = src[13] ^ src[4] ^ src[2] ^ src[0];
        src = {src[12:0], b};
    endtask

    // Behavioural model: bit histories held as queues, newest at the back
    int     m_mode;   // 0 fill, 1 hunt, 2 locked
    bit     m_hist[$];
    bit     m_gen[$];
    int     m_fill, m_match, m_win, m_werr;
    longint m_err, m_bits;
    bit     m_pulse, m_locked;

    function automatic bit pred_of(input bit q[$]);
        // newest bit is q[13]; taps at ages 13, 4, 2, 0
        return q[0] ^ q[9] ^ q[11] ^ q[13];
    endfunction

    task automatic model_step(input bit rs, input bit v, input bit d, input bit c);
        bit p;
        bit nz;
        if (rs) begin
            m_mode = 0; m_hist.delete(); m_gen.delete();
            m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
            m_err = 0; m_bits = 0; m_pulse = 0; m_locked = 0;
            return;
        end
        m_pulse = 0;
        if (v) begin
            if (m_mode == 0) begin
                m_hist.push_back(d);
                if (m_hist.size() > 14) void'(m_hist.pop_front());
                m_fill++;
                if (m_fill == 14) begin
                    m_mode = 1; m_fill = 0; m_match = 0;
                end
            end else if (m_mode == 1) begin
                p  = pred_of(m_hist);
                nz = 0;
                foreach (m_hist[i]) nz |= m_hist[i];
                m_hist.push_back(d);
                void'(m_hist.pop_front());
                if (d == p && nz) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_mode = 2; m_gen = m_hist; m_locked = 1;
                        m_win = 0; m_werr = 0; m_match = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                p = pred_of(m_gen);
                m_gen.push_back(p);
                void'(m_gen.pop_front());
                if (m_bits < SAT) m_bits++;
                if (d != p) begin
                    m_pulse = 1;
                    if (m_err < SAT) m_err++;
                    m_werr++;
                end
                if (m_werr == UNLOCK_ERR) begin
                    m_mode = 0; m_locked = 0; m_hist.delete();
                    m_fill = 0; m_win = 0; m_werr = 0;
                end else begin
                    m_win++;
                    if (m_win == WINDOW) begin
                        m_win = 0; m_werr = 0;
                    end
                end
            end
        end
        if (c) begin
            m_err = 0; m_bits = 0;
        end
    endtask

    task automatic tick(input bit rs, input bit v, input bit d, input bit c);
        @(negedge clk);
        rst = rs; din_valid = v; din = d; clr_counts = c;
        @(posedge clk);
        model_step(rs, v, d, c);
        #1;
    endtask

    task automatic do_lock(input logic [13:0] seed);
        bit b;
        tick(1, 0, 0, 0);
        src = seed;
        for (int k = 0; k < 46; k++) begin
            src_step(b);
            tick(0, 1, b, 0);
        end
    endtask

    task automatic test_reset;
        tick(1, 1, 1, 1);
        tick(1, 0, 0, 0);
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %b expected 0", err_pulse); end
        n_cmp++; if (err_count !== 32'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        n_cmp++; if (bit_count !== 32'd0) begin n_fail++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
    endtask

    task automatic test_lock_acquire;
        bit b;
        int first = 0;
        src = 14'h0001;
        for (int k = 1; k <= 70; k++) begin
            src_step(b);
            tick(0, 1, b, 0);
            if (locked === 1'b1 && first == 0) first = k;
            got = {locked, err_pulse, err_count, bit_count};
            want = {m_locked, m_pulse, m_err[31:0], m_bits[31:0]};
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL acquire bit %0d: got %h expected %h", k, got, want); end
        end
        n_cmp++; if (first != 46) begin n_fail++; $display("FAIL acquire_latency: got %0d expected 46", first); end
        n_cmp++; if (bit_count !== 32'd24 || err_count !== 32'd0) begin
            n_fail++; $display("FAIL acquire_counts: got b=%0d e=%0d expected b=24 e=0", bit_count, err_count);
        end
    endtask

    task automatic test_single_error;
        bit b;
        int pulses = 0;
        src_step(b);
        tick(0, 1, ~b, 0);
        if (err_pulse === 1'b1) pulses++;
        for (int k = 0; k < 500; k++) begin
            src_step(b);
            tick(0, 1, b, 0);
            if (err_pulse === 1'b1) pulses++;
            got = {locked, err_pulse, err_count, bit_count};
            want = {m_locked, m_pulse, m_err[31:0], m_bits[31:0]};
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL single_err bit %0d: got %h expected %h", k, got, want); end
        end
        n_cmp++; if (pulses != 1 || err_count !== 32'd1 || locked !== 1'b1) begin
            n_fail++; $display("FAIL single_err_summary: got pulses=%0d e=%0d l=%b expected 1 1 1", pulses, err_count, locked);
        end
    endtask

    task automatic test_stuck_zero;
        bit ever = 0;
        tick(1, 0, 0, 0);
        for (int k = 0; k < 2000; k++) begin
            tick(0, 1, 0, 0);
            ever |= (locked !== 1'b0);
        end
        n_cmp++; if (ever || err_count !== 32'd0) begin
            n_fail++; $display("FAIL stuck_zero: got ever_locked=%b e=%0d expected 0 0", ever, err_count);
        end
    endtask

    task automatic test_unlock_relock;
        bit b;
        int fall = 0;
        int relock = 0;
        do_lock(14'($urandom_range(1, 16383)));
        for (int k = 0; k < 100; k++) begin
            src_step(b);
            tick(0, 1, (k % 10 == 5 && k < 80) ? ~b : b, 0);
            if (locked === 1'b0 && fall == 0) fall = k;
            got = {locked, err_pulse, err_count, bit_count};
            want = {m_locked, m_pulse, m_err[31:0], m_bits[31:0]};
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL unlock bit %0d: got %h expected %h", k, got, want); end
        end
        n_cmp++; if (fall != 75 || err_count !== 32'd8) begin
            n_fail++; $display("FAIL unlock_point: got fall=%0d e=%0d expected 75 8", fall, err_count);
        end
        // 24 clean bits already sent after the unlock; keep going until relock
        relock = 24;
        for (int k = 0; k < 200 && locked !== 1'b1; k++) begin
            src_step(b);
            tick(0, 1, b, 0);
            relock++;
        end
        n_cmp++; if (relock != 46 || locked !== 1'b1 || err_count !== 32'd8) begin
            n_fail++; $display("FAIL relock: got bits=%0d l=%b e=%0d expected 46 1 8", relock, locked, err_count);
        end
    endtask

    task automatic test_clr_collision;
        bit b;
        do_lock(14'($urandom_range(1, 16383)));
        for (int k = 0; k < 5; k++) begin
            src_step(b);
            tick(0, 1, b, 0);
        end
        src_step(b);
        tick(0, 1, ~b, 1);
        n_cmp++; if ({err_pulse, err_count, bit_count} !== {1'b1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL clr_collision: got p=%b e=%0d b=%0d expected 1 0 0", err_pulse, err_count, bit_count);
        end
        src_step(b);
        tick(0, 1, b, 0);
        n_cmp++; if ({err_pulse, err_count, bit_count, locked} !== {1'b0, 32'd0, 32'd1, 1'b1}) begin
            n_fail++; $display("FAIL clr_after: got p=%b e=%0d b=%0d l=%b expected 0 0 1 1", err_pulse, err_count, bit_count, locked);
        end
    endtask

    task automatic test_random_valid;
        bit b;
        bit v;
        int nvalid = 0;
        do_lock(14'($urandom_range(1, 16383)));
        for (int k = 0; k < 400; k++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                src_step(b);
                nvalid++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            tick(0, v, b, 0);
            got = {locked, err_pulse, err_count, bit_count};
            want = {m_locked, m_pulse, m_err[31:0], m_bits[31:0]};
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL rand_valid cyc %0d: got %h expected %h", k, got, want); end
        end
        n_cmp++; if (bit_count !== 32'(nvalid)) begin
            n_fail++; $display("FAIL rand_valid_count: got %0d expected %0d", bit_count, nvalid);
        end
        tick(1, 1, 1, 0);
        n_cmp++; if ({locked, err_pulse, err_count, bit_count} !== 66'd0) begin
            n_fail++; $display("FAIL rst_mid_lock: got %h expected 0", {locked, err_pulse, err_count, bit_count});
        end
    endtask

    task automatic test_random_mix;
        bit b;
        bit v;
        bit c;
        do_lock(14'($urandom_range(1, 16383)));
        for (int k = 0; k < 1500; k++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) == 0);
            if (v) begin
                src_step(b);
                if ($urandom_range(0, 29) == 0) b = ~b;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            tick(0, v, b, c);
            got = {locked, err_pulse, err_count, bit_count};
            want = {m_locked, m_pulse, m_err[31:0], m_bits[31:0]};
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL rand_mix cyc %0d: got %h expected %h", k, got, want); end
        end
    endtask

    initial begin
        test_reset;
        test_lock_acquire;
        test_single_error;
        test_stuck_zero;
        test_unlock_relock;
        test_clr_collision;
        test_random_valid;
        test_random_mix;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
